conv_pool_requant: RTL and testbench
====================================

// Module: conv_pool_requant
// PURPOSE
// - Downstream stage of the 4x4 convolution MAC array; consumes its 16x16-bit result tile on the done pulse.
// - Per element: bias add, ReLU, right-shift requantise, saturate to 8-bit unsigned (next-layer input_tile format).
// - 2x2 max-pool to 2x2 bytes, streamed out with valid/ready toward the tile buffer / next layer.
// PARAMETERS
// - TILE    4    result tile edge, elements per side (fixed 4; pooling logic assumes even value)
// - IN_W    16   width of each incoming conv result element
// - OUT_W   8    width of each outgoing pooled element
// PORTS
// - clk          in   1        system clock, rising edge
// - rst_n        in   1        asynchronous active-low reset
// - in_done      in   1        one-cycle pulse from conv stage: c[][] valid this cycle
// - c            in   16x16    c[0:3][0:3] conv results, unsigned
// - bias         in   16       signed bias, sampled with tile
// - shift        in   4        requant right-shift amount 0..15, sampled with tile
// - out_valid    out  1        out_data valid
// - out_ready    in   1        downstream accepts when out_valid && out_ready
// - out_data     out  8        pooled element, unsigned
// - out_last     out  1        high with 4th (final) element of tile
// - busy         out  1        high in any state but IDLE
// - overflow     out  1        sticky: tile arrived while unable to accept
// - overflow_clr in   1        synchronous clear of overflow
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, out_valid=0, out_data=0, out_last=0, busy=0, overflow=0,
//   captured tile/bias/shift/result buffer=0. Reset mid-operation drops the tile; no partial output.
// - FSM: IDLE -> POST (in_done) ; POST -> POST x4 (win 0..3) ; POST(win3) -> OUT ; OUT -> IDLE on final handshake.
// - IDLE: on in_done, register c, bias, shift; go to POST, win=0.
// - POST: one pool window per cycle, result written to 4-entry buffer.
//   Window k: rows 2*(k/2)..+1, cols 2*(k%2)..+1 (0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right).
// - Element math: v = $signed({2'b0,c}) + $signed(bias), 18-bit signed; v<0 -> 0;
//   r = v >> shift; r>255 -> 255; pooled = max of the 4 requantised values.
// - Latency: in_done at edge T -> out_valid first high after edge T+5 (capture + 4 POST cycles).
// - OUT: present buffer[0..3] in order; out_valid high, out_data/out_last stable until handshake;
//   index advances only on out_valid && out_ready; out_last=1 only for index 3.
// - out_ready high in consecutive cycles streams 1 element/cycle; out_ready low stalls indefinitely.
// - in_done while busy sets overflow, tile ignored, in-flight tile unaffected.
//   Exception: in_done in the same cycle as the final OUT handshake is accepted (back-to-back), no overflow.
// - overflow_clr and a new overflow event in the same cycle: overflow stays 1 (set wins).
// - shift=0: no shift; shift=15: only v>=32768 produces nonzero.
// STRUCTURE
// - npu_pkg: typedef enum {IDLE, POST, OUT} pool_state_t; localparams TILE=4, POOL=2, OUT_MAX=255.
// - Sub-module requant_relu_sat (combinational: 16-bit c, bias, shift -> 8-bit), 4 instances, one per window element.
// - Top: FSM, window/output counters, capture regs, 2-level max tree, 4x8 result buffer.
// TESTING
// - All c=16, bias=0, shift=2, out_ready=1 -> 4 outputs of 4, out_last on 4th, first out_valid 5 cycles after in_done.
// - c[0][0..1]=10,20, c[1][0..1]=30,300, rest 0, bias=0, shift=0 -> outputs 255,0,0,0 (saturation).
// - All c=50, bias=-100 -> outputs 0,0,0,0 (ReLU). All c=50, bias=+14, shift=3 -> outputs 8.
// - out_ready low 10 cycles in OUT -> out_valid=1, out_data/out_last unchanged; then release -> remaining elements in order.
// - in_done during POST -> overflow=1, first tile outputs correct, second tile never emitted;
//   overflow_clr -> overflow=0 next cycle.
// - in_done on final handshake -> second tile emitted, overflow=0;
//   rst_n low during OUT -> out_valid=0, busy=0 immediately, no further outputs.

Source files
------------

// File: rtl/conv_pool_requant_pkg.sv
// Shared types and constants for the conv result post-processing stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package npu_pkg;

    localparam int TILE    = 4;
    localparam int POOL    = 2;
    localparam int OUT_MAX = 255;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int BIAS_W  = 16;
    localparam int SHIFT_W = 4;
    localparam int NWIN    = (TILE / POOL) * (TILE / POOL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POST = 2'd1,
        OUT  = 2'd2
    } pool_state_t;

    typedef logic [IN_W-1:0] elem_t;
    // Indexed as tile[row][col].
    typedef elem_t [TILE-1:0][TILE-1:0] tile_t;

    function automatic logic [OUT_W-1:0] max_u8(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_pool_requant_if.sv
// Tile-in / pooled-byte-out bundle between conv stage, pool stage and tile buffer.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready on the output side; in_done is an unconditional pulse.
// Ports: in_done, c, bias, shift flow toward the pool stage; out_valid, out_data,
// out_last flow away from it; out_ready flows back toward it.
interface conv_pool_requant_if;
    import npu_pkg::*;

    logic                      in_done;
    tile_t                     c;
    logic signed [BIAS_W-1:0]  bias;
    logic [SHIFT_W-1:0]        shift;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          out_data;
    logic                      out_last;

    // Controller side: issues tiles and consumes pooled bytes.
    modport master (
        output in_done, c, bias, shift, out_ready,
        input  out_valid, out_data, out_last
    );

    // Pool stage side.
    modport slave (
        input  in_done, c, bias, shift, out_ready,
        output out_valid, out_data, out_last
    );

endinterface

// File: rtl/conv_pool_requant_requant_relu_sat.sv
// Per-element bias add, ReLU, right-shift requantise and saturate to unsigned 8-bit.
// Latency: combinational.
// Backpressure: none.
// Ports: c (unsigned conv result), bias (signed), shift (0..15) -> q (unsigned byte).
module requant_relu_sat
    import npu_pkg::*;
(
    input  logic [IN_W-1:0]          c,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic [SHIFT_W-1:0]       shift,
    output logic [OUT_W-1:0]         q
);

    // 18 bits holds 65535 + 32767 and 0 - 32768 without wrap.
    logic signed [17:0] v;
    logic [16:0]        r;

    always_comb begin
        v = $signed({2'b00, c}) + $signed({{2{bias[BIAS_W-1]}}, bias});
        r = '0;
        if (!v[17]) begin
            r = v[16:0] >> shift;
        end
        q = (r > 17'(OUT_MAX)) ? OUT_W'(OUT_MAX) : r[OUT_W-1:0];
    end

endmodule

// File: rtl/conv_pool_requant.sv
// Requantise a 4x4 conv result tile and 2x2 max-pool it into 4 bytes streamed out in raster order.
// Latency: in_done sampled at edge T -> first out_valid after edge T+5 (capture, 4 window cycles, output load).
// Backpressure: output holds under out_ready low indefinitely; tiles arriving while busy are dropped and flagged.
// Ports: clk, rst_n (async active-low); bus (slave: tile in, pooled byte stream out);
// busy (not idle), overflow (sticky dropped-tile flag), overflow_clr (synchronous clear).
module conv_pool_requant
    import npu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    conv_pool_requant_if.slave  bus,
    output logic                busy,
    output logic                overflow,
    input  logic                overflow_clr
);

    pool_state_t               state;
    logic [1:0]                win;
    logic [1:0]                idx;
    tile_t                     cap_c;
    logic signed [BIAS_W-1:0]  cap_bias;
    logic [SHIFT_W-1:0]        cap_shift;
    logic [OUT_W-1:0]          res_buf [NWIN];

    logic                      out_valid_r;
    logic [OUT_W-1:0]          out_data_r;
    logic                      out_last_r;

    // Current pool window: top-left corner at row 2*win[1], col 2*win[0].
    logic [1:0] r0, r1, c0, c1;
    elem_t      e [4];
    logic [OUT_W-1:0] q [4];
    logic [OUT_W-1:0] pooled;

    assign r0 = {win[1], 1'b0};
    assign r1 = {win[1], 1'b1};
    assign c0 = {win[0], 1'b0};
    assign c1 = {win[0], 1'b1};

    always_comb begin
        e[0] = cap_c[r0][c0];
        e[1] = cap_c[r0][c1];
        e[2] = cap_c[r1][c0];
        e[3] = cap_c[r1][c1];
    end

    for (genvar g = 0; g < 4; g++) begin : g_rq
        requant_relu_sat u_rq (
            .c     (e[g]),
            .bias  (cap_bias),
            .shift (cap_shift),
            .q     (q[g])
        );
    end

    assign pooled = max_u8(max_u8(q[0], q[1]), max_u8(q[2], q[3]));

    // The final handshake frees the stage in the same cycle, so a tile
    // arriving exactly then is taken rather than counted as an overflow.
    logic final_hs;
    logic accept;

    assign final_hs = (state == OUT) && out_valid_r && bus.out_ready && (idx == 2'd3);
    assign accept   = bus.in_done && ((state == IDLE) || final_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win         <= '0;
            idx         <= '0;
            cap_c       <= '0;
            cap_bias    <= '0;
            cap_shift   <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            for (int i = 0; i < NWIN; i++) begin
                res_buf[i] <= '0;
            end
        end else begin
            if (accept) begin
                cap_c     <= bus.c;
                cap_bias  <= bus.bias;
                cap_shift <= bus.shift;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= POST;
                        win   <= '0;
                    end
                end
                POST: begin
                    res_buf[win] <= pooled;
                    win          <= win + 2'd1;
                    if (win == 2'd3) begin
                        state <= OUT;
                        idx   <= '0;
                    end
                end
                OUT: begin
                    if (!out_valid_r) begin
                        // First cycle in OUT: the buffer is complete, load element 0.
                        out_valid_r <= 1'b1;
                        out_data_r  <= res_buf[0];
                        out_last_r  <= 1'b0;
                    end else if (bus.out_ready) begin
                        if (idx == 2'd3) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            if (accept) begin
                                state <= POST;
                                win   <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx        <= idx + 2'd1;
                            out_data_r <= res_buf[idx + 2'd1];
                            out_last_r <= (idx == 2'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set takes priority over clear so a drop in the clear cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (bus.in_done && !accept) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    assign busy          = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_conv_pool_requant.sv
// Bench for conv_pool_requant: directed tiles, stalls, overflow, back-to-back, reset, random traffic.
// Latency: n/a.
// Backpressure: out_ready driven directly and randomly.
module tb_conv_pool_requant;
    import npu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic overflow_clr = 1'b0;
    logic busy;
    logic overflow;

    conv_pool_requant_if bus ();

    conv_pool_requant dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef logic [3:0][7:0] quad_t;

    function automatic int rq(input int cv, input int b, input int s);
        int v;
        v = cv + b;
        if (v < 0) v = 0;
        v = v >>> s;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic quad_t pool_tile(input tile_t t, input int b, input int s);
        quad_t res;
        for (int k = 0; k < 4; k++) begin
            int m = 0;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    int v;
                    v = rq(int'(t[2*(k/2)+dr][2*(k%2)+dc]), b, s);
                    if (v > m) m = v;
                end
            end
            res[k] = 8'(m);
        end
        return res;
    endfunction

    function automatic tile_t fill(input int v);
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                t[r][cc] = 16'(v);
        return t;
    endfunction

    // Abstract stage state: one tile in flight, outputs from 5 cycles after acceptance.
    int  exp_q[$];
    int  exp_idx  = 0;
    bit  m_busy   = 0;
    int  age      = 0;
    bit  ov_exp   = 0;
    int  dut_tiles = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data",  bus.out_data, 0);
            chk("rst_out_last",  bus.out_last, 0);
            chk("rst_busy",      busy, 0);
            chk("rst_overflow",  overflow, 0);
            exp_q.delete();
            exp_idx = 0;
            m_busy  = 0;
            age     = 0;
            ov_exp  = 0;
        end else begin
            bit ev, hs, acc;
            ev = m_busy && (age >= 5);
            chk("out_valid", bus.out_valid, ev);
            chk("busy", busy, m_busy);
            chk("overflow", overflow, ov_exp);
            if (ev) begin
                if (exp_q.size() == 0) begin
                    chk("exp_queue_nonempty", 0, 1);
                end else begin
                    chk("out_data", bus.out_data, exp_q[0]);
                    chk("out_last", bus.out_last, (exp_idx == 3));
                end
            end
            if (bus.out_valid && bus.out_ready && bus.out_last) dut_tiles++;
            hs = ev && bus.out_ready && (exp_q.size() != 0);
            if (hs) begin
                void'(exp_q.pop_front());
                if (exp_idx == 3) begin
                    m_busy  = 0;
                    exp_idx = 0;
                end else begin
                    exp_idx++;
                end
            end
            acc = bus.in_done && !m_busy;
            if (bus.in_done && !acc) ov_exp = 1;
            else if (overflow_clr)   ov_exp = 0;
            if (acc) begin
                quad_t qq;
                qq = pool_tile(bus.c, int'(bus.bias), int'(bus.shift));
                for (int k = 0; k < 4; k++) exp_q.push_back(int'(qq[k]));
                m_busy  = 1;
                age     = 0;
                exp_idx = 0;
            end else if (m_busy) begin
                age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tile(input tile_t t, input int b, input int s);
        bus.c       = t;
        bus.bias    = 16'(b);
        bus.shift   = 4'(s);
        bus.in_done = 1'b1;
        tick();
        bus.in_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_busy) break;
            tick();
        end
        chk(name, m_busy, 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        chk(name, bus.out_valid, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        quad_t qm;
        tile_t t;
        int    base;

        bus.in_done   = 1'b0;
        bus.c         = '0;
        bus.bias      = '0;
        bus.shift     = '0;
        bus.out_ready = 1'b1;

        // Pin the model with hand-computed results.
        qm = pool_tile(fill(16), 0, 2);
        chk("model_all16_s2", qm, 32'h04040404);
        t = fill(0);
        t[0][0] = 16'd10; t[0][1] = 16'd20; t[1][0] = 16'd30; t[1][1] = 16'd300;
        qm = pool_tile(t, 0, 0);
        chk("model_saturate", qm, 32'h000000FF);
        qm = pool_tile(fill(50), -100, 0);
        chk("model_relu", qm, 32'h00000000);
        qm = pool_tile(fill(50), 14, 3);
        chk("model_bias_shift3", qm, 32'h08080808);
        qm = pool_tile(fill(65535), 0, 15);
        chk("model_shift15_hi", qm, 32'h01010101);
        qm = pool_tile(fill(32767), 0, 15);
        chk("model_shift15_lo", qm, 32'h00000000);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Directed tiles with free-flowing output.
        send_tile(fill(16), 0, 2);
        wait_idle("drain_all16", 40);
        send_tile(t, 0, 0);
        wait_idle("drain_saturate", 40);
        send_tile(fill(50), -100, 0);
        wait_idle("drain_relu", 40);
        send_tile(fill(50), 14, 3);
        wait_idle("drain_bias", 40);
        send_tile(fill(65535), 0, 15);
        wait_idle("drain_shift15", 40);

        // Stall 10 cycles on the first element, then release.
        bus.out_ready = 1'b0;
        t = fill(0);
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                t[r][cc] = 16'((r * 4 + cc) * 13);
        send_tile(t, 5, 1);
        wait_valid("stall_first_valid", 20);
        repeat (10) tick();
        bus.out_ready = 1'b1;
        wait_idle("drain_stall", 40);

        // Tile during POST is dropped and flagged; clear afterwards.
        base = dut_tiles;
        send_tile(fill(200), 0, 0);
        tick();
        send_tile(fill(7), 0, 0);
        wait_idle("drain_overflow", 40);
        tick();
        chk("ovf_tile_count", dut_tiles - base, 1);
        chk("ovf_flag_set", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_flag_clr", overflow, 0);

        // Clear coinciding with a new drop: flag must stay set.
        send_tile(fill(90), -10, 2);
        bus.c = fill(3);
        bus.in_done  = 1'b1;
        overflow_clr = 1'b1;
        tick();
        bus.in_done  = 1'b0;
        overflow_clr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        wait_idle("drain_setwins", 40);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;

        // Back-to-back: new tile on the final handshake.
        base = dut_tiles;
        send_tile(fill(1000), 24, 4);
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid && bus.out_last) break;
            tick();
        end
        chk("b2b_at_last", bus.out_last, 1);
        send_tile(fill(333), -300, 0);
        wait_idle("drain_b2b", 40);
        tick();
        chk("b2b_tile_count", dut_tiles - base, 2);
        chk("b2b_no_overflow", overflow, 0);

        // Randomised traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < 4; r++) begin
                for (int cc = 0; cc < 4; cc++) begin
                    case ($urandom % 3)
                        0:       bus.c[r][cc] = 16'($urandom % 256);
                        1:       bus.c[r][cc] = 16'($urandom % 4096);
                        default: bus.c[r][cc] = 16'($urandom);
                    endcase
                end
            end
            bus.bias      = ($urandom % 2 == 0) ? 16'(int'($urandom_range(0, 511)) - 256)
                                                : 16'($urandom);
            bus.shift     = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 6);
            bus.in_done   = ($urandom % 9 == 0);
            bus.out_ready = ($urandom % 4 != 0);
            overflow_clr  = ($urandom % 16 == 0);
            tick();
        end
        bus.in_done   = 1'b0;
        overflow_clr  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle("drain_random", 40);

        // Reset while presenting output: everything drops, nothing more emitted.
        bus.out_ready = 1'b0;
        send_tile(fill(4000), 100, 5);
        wait_valid("rst_pre_valid", 20);
        base = dut_tiles;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", bus.out_valid, 0);
        chk("rst_async_busy", busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("rst_no_output", dut_tiles - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
